// File: rtl/mac_neuron_q34.sv
// Sequential multiply-accumulate neuron: bias plus N_INPUTS signed Q3.4 products,
// accumulated in saturating Q10.8 with an optional ReLU on the final result.
module mac_neuron_q34 #(
  parameter int N_INPUTS   = 2,
  parameter int RELU_EN    = 0,
  parameter int DATA_WIDTH = 19
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_x,
  input  logic [7:0]            in_w,
  input  logic [7:0]            bias,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_ovf
);

  localparam int CW = $clog2(N_INPUTS) + 1;
  localparam int SW = DATA_WIDTH + 1;

  typedef enum logic {S_ACC = 1'b0, S_OUT = 1'b1} state_t;

  state_t                state_reg;
  state_t                state_next;
  logic [CW-1:0]         cnt_reg;
  logic [DATA_WIDTH-1:0] acc_reg;
  logic                  ovf_int_reg;
  logic [DATA_WIDTH-1:0] out_data_reg;
  logic                  out_ovf_reg;

  logic                  accept;
  logic                  first_beat;
  logic                  last_beat;
  logic signed [15:0]    product;
  logic [SW-1:0]         base;
  logic [SW-1:0]         sum;
  logic                  pos_sat;
  logic                  neg_sat;
  logic [DATA_WIDTH-1:0] sat_sum;
  logic [DATA_WIDTH-1:0] relu_sum;
  logic                  ovf_vec;

  assign accept     = in_valid && in_ready;
  assign first_beat = (cnt_reg == '0);
  assign last_beat  = (cnt_reg == CW'(N_INPUTS - 1));

  assign product = $signed(in_x) * $signed(in_w);

  // First beat starts from the bias rescaled Q3.4 -> Q10.8 instead of the stale accumulator.
  assign base = first_beat ? {{(SW-12){bias[7]}}, bias, 4'b0000}
                           : {acc_reg[DATA_WIDTH-1], acc_reg};
  assign sum  = base + {{(SW-16){product[15]}}, product};

  // One guard bit is enough: base and product together never exceed the 20-bit range.
  assign pos_sat = ~sum[SW-1] &  sum[SW-2];
  assign neg_sat =  sum[SW-1] & ~sum[SW-2];

  always_comb begin
    sat_sum = sum[DATA_WIDTH-1:0];
    if (pos_sat) begin
      sat_sum = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else if (neg_sat) begin
      sat_sum = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end
  end

  assign ovf_vec  = (~first_beat & ovf_int_reg) | pos_sat | neg_sat;
  assign relu_sum = ((RELU_EN != 0) && sat_sum[DATA_WIDTH-1]) ? '0 : sat_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_ACC;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_ACC:   if (accept && last_beat) state_next = S_OUT;
      S_OUT:   if (out_ready) state_next = S_ACC;
      default: state_next = S_ACC;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_reg)
      S_ACC:   in_ready  = 1'b1;
      S_OUT:   out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg      <= '0;
      acc_reg      <= '0;
      ovf_int_reg  <= 1'b0;
      out_data_reg <= '0;
      out_ovf_reg  <= 1'b0;
    end else if (accept) begin
      // Later beats continue from the clamped value, not the wrapped sum.
      acc_reg     <= sat_sum;
      ovf_int_reg <= ovf_vec;
      if (last_beat) begin
        cnt_reg      <= '0;
        out_data_reg <= relu_sum;
        out_ovf_reg  <= ovf_vec;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

  assign out_data = out_data_reg;
  assign out_ovf  = out_ovf_reg;

endmodule

// File: tb/tb_mac_neuron_q34.sv
// Self-checking bench for mac_neuron_q34: five parameter variants on one clock,
// directed table, hand-written timing sequences and randomized vectors vs. a model.
module tb_mac_neuron_q34;

  localparam int NL = 5;
  localparam int LN [NL] = '{2, 2, 16, 1, 20};
  localparam int LR [NL] = '{0, 1, 0, 0, 0};

  logic          clk;
  logic          rst;
  logic [NL-1:0] valid;
  logic [NL-1:0] iready;
  logic [NL-1:0] ovalid;
  logic [NL-1:0] oovf;
  logic [18:0]   odata [NL];
  logic [7:0]    x;
  logic [7:0]    w;
  logic [7:0]    bias;
  logic          out_ready;

  int checks;
  int failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NL; gi++) begin : g_lane
    mac_neuron_q34 #(
      .N_INPUTS  (LN[gi]),
      .RELU_EN   (LR[gi]),
      .DATA_WIDTH(19)
    ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (valid[gi]),
      .in_ready (iready[gi]),
      .in_x     (x),
      .in_w     (w),
      .bias     (bias),
      .out_valid(ovalid[gi]),
      .out_ready(out_ready),
      .out_data (odata[gi]),
      .out_ovf  (oovf[gi])
    );
  end

  typedef struct {
    int          lane;
    logic [7:0]  b;
    logic [7:0]  xa;
    logic [7:0]  wa;
    logic [7:0]  xb;
    logic [7:0]  wb;
    logic [18:0] d;
    logic        o;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic with per-beat clamping to the Q10.8 range.
  function automatic logic [19:0] model(input int n, input int relu, input logic [7:0] b,
                                        input logic [7:0] xs [20], input logic [7:0] ws [20]);
    int acc;
    bit ovf;
    acc = 16 * int'($signed(b));
    ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      acc += int'($signed(xs[i])) * int'($signed(ws[i]));
      if (acc > 262143) begin
        acc = 262143;
        ovf = 1'b1;
      end else if (acc < -262144) begin
        acc = -262144;
        ovf = 1'b1;
      end
    end
    if (relu != 0 && acc < 0) acc = 0;
    return {ovf, acc[18:0]};
  endfunction

  task automatic beat(input int lane, input logic [7:0] bx, input logic [7:0] bw, input logic [7:0] bb);
    int t;
    t = 0;
    @(negedge clk);
    x = bx;
    w = bw;
    bias = bb;
    valid[lane] = 1'b1;
    while (!iready[lane] && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      checks++;
      failures++;
      $display("FAIL beat_timeout lane=%0d: in_ready got 0 required 1", lane);
    end
    @(posedge clk);
    #1 valid[lane] = 1'b0;
  endtask

  task automatic get_result(input int lane, input int hold, output logic [18:0] d, output logic o);
    int t;
    t = 0;
    d = '0;
    o = 1'b0;
    @(negedge clk);
    while (!ovalid[lane] && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      checks++;
      failures++;
      $display("FAIL result_timeout lane=%0d: out_valid got 0 required 1", lane);
    end else begin
      d = odata[lane];
      o = oovf[lane];
      if (hold > 0) begin
        out_ready = 1'b0;
        repeat (hold) @(negedge clk);
        chk("hold_stable", {12'd0, ovalid[lane], oovf[lane], odata[lane]}, {12'd0, 1'b1, o, d});
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_vec(input int lane, input logic [7:0] b, input logic [7:0] xs [20],
                         input logic [7:0] ws [20], input int gap_max, input int hold,
                         input string name, input logic [18:0] exp_d, input logic exp_o);
    logic [18:0] d;
    logic        o;
    for (int i = 0; i < LN[lane]; i++) begin
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
      beat(lane, xs[i], ws[i], (i == 0) ? b : 8'($urandom));
    end
    get_result(lane, hold, d, o);
    $display("vec %s lane=%0d data=%05h ovf=%0b exp=%05h/%0b", name, lane, d, o, exp_d, exp_o);
    chk({name, "_data"}, {13'd0, d}, {13'd0, exp_d});
    chk({name, "_ovf"}, {31'd0, o}, {31'd0, exp_o});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    valid = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation got no end required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  xs [20];
    logic [7:0]  ws [20];
    logic [19:0] r;
    logic [18:0] d;
    logic        o;
    int          lane;

    checks = 0;
    failures = 0;
    rst = 1'b1;
    valid = '0;
    x = '0;
    w = '0;
    bias = '0;
    out_ready = 1'b1;

    tbl[0]  = '{0, 8'h00, 8'h10, 8'h18, 8'h20, 8'hF0, 19'h7FF80, 1'b0};
    tbl[1]  = '{1, 8'h00, 8'h10, 8'h18, 8'h20, 8'hF0, 19'h00000, 1'b0};
    tbl[2]  = '{1, 8'h08, 8'h10, 8'h10, 8'h10, 8'h10, 19'h00280, 1'b0};
    tbl[3]  = '{0, 8'h08, 8'h10, 8'h10, 8'h10, 8'h10, 19'h00280, 1'b0};
    tbl[4]  = '{2, 8'h7F, 8'h80, 8'h80, 8'h80, 8'h80, 19'h3FFFF, 1'b1};
    tbl[5]  = '{2, 8'h00, 8'h10, 8'h10, 8'h10, 8'h10, 19'h01000, 1'b0};
    tbl[6]  = '{2, 8'h80, 8'h80, 8'h7F, 8'h80, 8'h7F, 19'h40000, 1'b0};
    tbl[7]  = '{2, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 19'h3F800, 1'b0};
    tbl[8]  = '{3, 8'h10, 8'h00, 8'h00, 8'h10, 8'h10, 19'h00200, 1'b0};
    tbl[9]  = '{3, 8'h80, 8'h00, 8'h00, 8'h80, 8'h7F, 19'h7B880, 1'b0};
    tbl[10] = '{4, 8'h00, 8'h80, 8'h80, 8'h80, 8'h7F, 19'h3C07F, 1'b1};
    tbl[11] = '{4, 8'h80, 8'h80, 8'h7F, 8'h10, 8'h10, 19'h40100, 1'b1};
    tbl[12] = '{1, 8'h80, 8'h80, 8'h7F, 8'h80, 8'h80, 19'h00000, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_out_valid", {27'd0, ovalid}, 32'd0);
    chk("reset_out_ovf", {27'd0, oovf}, 32'd0);
    chk("reset_in_ready", {27'd0, iready}, 32'h1F);
    chk("reset_out_data", {13'd0, odata[0]}, 32'd0);

    // Back-to-back basic MAC: result one cycle after the last beat, in_ready low for one cycle.
    beat(0, 8'h10, 8'h18, 8'h00);
    beat(0, 8'h20, 8'hF0, 8'h00);
    @(negedge clk);
    chk("lat_out_valid", {31'd0, ovalid[0]}, 32'd1);
    chk("lat_in_ready", {31'd0, iready[0]}, 32'd0);
    chk("lat_out_data", {13'd0, odata[0]}, 32'h7FF80);
    chk("lat_out_ovf", {31'd0, oovf[0]}, 32'd0);
    @(negedge clk);
    chk("post_out_valid", {31'd0, ovalid[0]}, 32'd0);
    chk("post_in_ready", {31'd0, iready[0]}, 32'd1);

    for (int k = 0; k < 13; k++) begin
      for (int i = 0; i < 20; i++) begin
        xs[i] = (i == LN[tbl[k].lane] - 1) ? tbl[k].xb : tbl[k].xa;
        ws[i] = (i == LN[tbl[k].lane] - 1) ? tbl[k].wb : tbl[k].wa;
      end
      run_vec(tbl[k].lane, tbl[k].b, xs, ws, 0, 0, $sformatf("tbl%0d", k), tbl[k].d, tbl[k].o);
    end

    // Backpressure: result held, new beats offered but not consumed.
    out_ready = 1'b0;
    beat(0, 8'h10, 8'h18, 8'h00);
    beat(0, 8'h20, 8'hF0, 8'h00);
    @(negedge clk);
    x = 8'h7F;
    w = 8'h7F;
    bias = 8'h40;
    valid[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_out_valid", {31'd0, ovalid[0]}, 32'd1);
      chk("bp_in_ready", {31'd0, iready[0]}, 32'd0);
      chk("bp_out_data", {13'd0, odata[0]}, 32'h7FF80);
      chk("bp_out_ovf", {31'd0, oovf[0]}, 32'd0);
    end
    valid[0] = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) begin
      xs[i] = 8'h10;
      ws[i] = 8'h10;
    end
    run_vec(0, 8'h08, xs, ws, 0, 0, "bp_next", 19'h00280, 1'b0);

    // Bubbles between beats change nothing.
    beat(0, 8'h10, 8'h18, 8'h00);
    repeat (3) @(negedge clk);
    beat(0, 8'h20, 8'hF0, 8'h55);
    get_result(0, 0, d, o);
    $display("vec bubbles lane=0 data=%05h ovf=%0b exp=7ff80/0", d, o);
    chk("bubble_data", {13'd0, d}, 32'h7FF80);

    // Reset after one beat discards it.
    beat(0, 8'h7F, 8'h7F, 8'h40);
    do_reset();
    beat(0, 8'h10, 8'h10, 8'h10);
    beat(0, 8'h00, 8'h7F, 8'h33);
    get_result(0, 0, d, o);
    $display("vec rst_mid lane=0 data=%05h ovf=%0b exp=00200/0", d, o);
    chk("rst_mid_data", {13'd0, d}, 32'h00200);
    chk("rst_mid_ovf", {31'd0, o}, 32'd0);

    // Reset while a result is pending drops it.
    out_ready = 1'b0;
    beat(0, 8'h10, 8'h10, 8'h10);
    beat(0, 8'h10, 8'h10, 8'h10);
    @(negedge clk);
    chk("rst_out_pending", {31'd0, ovalid[0]}, 32'd1);
    do_reset();
    chk("rst_out_valid", {31'd0, ovalid[0]}, 32'd0);
    chk("rst_out_data", {13'd0, odata[0]}, 32'd0);
    chk("rst_in_ready", {31'd0, iready[0]}, 32'd1);
    out_ready = 1'b1;

    for (int v = 0; v < 40; v++) begin
      lane = $urandom_range(0, NL - 1);
      for (int i = 0; i < 20; i++) begin
        xs[i] = 8'($urandom);
        ws[i] = 8'($urandom);
        if ($urandom_range(0, 1) == 1) xs[i] = ($urandom_range(0, 1) == 1) ? 8'h80 : 8'h7F;
        if ($urandom_range(0, 1) == 1) ws[i] = ($urandom_range(0, 1) == 1) ? 8'h80 : 8'h7F;
      end
      bias = 8'($urandom);
      r = model(LN[lane], LR[lane], bias, xs, ws);
      run_vec(lane, bias, xs, ws, 2, $urandom_range(0, 3), $sformatf("rnd%0d", v), r[18:0], r[19]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
